// File: rtl/uart_cmd_scheduler.sv
// uart_cmd_scheduler: two-requester round-robin front end for a UART regfile link.
// Ports: clk, reset (async high); req/wrb/addr/data 0|1 in; done 0|1, rd_data, err out;
// tx_data/ld_tx_data/tx_busy to the transmitter; rx_data/rx_empty/uld_rx_data to the receiver.
// Build option: define PARITY_CHECK_EN to also reject replies whose bit 17 parity is wrong.
module uart_cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wrb0,
  input  logic        wrb1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rd_data,
  output logic        err,
  output logic [17:0] tx_data,
  output logic        ld_tx_data,
  input  logic        tx_busy,
  input  logic [17:0] rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    WAIT_RX,
    UNLOAD,
    CHECK,
    FINISH
  } state_t;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        ptr_q, ptr_d;
  logic [17:0] pkt_q, pkt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [17:0] rply_q, rply_d;
  logic [7:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic        sel;
  logic        bad;

  function automatic logic [17:0] mk_pkt(
    input logic       w,
    input logic [7:0] a,
    input logic [7:0] d
  );
    logic [16:0] b;
    b = {a, w ? 8'h00 : d, w};
    return {^b, b};
  endfunction

  // On a tie ptr_q names the favoured requester
  assign sel = (req0 && req1) ? ptr_q : req1;

`ifdef PARITY_CHECK_EN
  assign bad = (rply_q[16:9] != pkt_q[16:9]) || !rply_q[0]
            || (rply_q[17] != ^rply_q[16:0]);
`else
  logic unused_par;
  assign unused_par = rply_q[17];
  assign bad = (rply_q[16:9] != pkt_q[16:9]) || !rply_q[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      pkt_q   <= '0;
      cnt_q   <= '0;
      rply_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      rply_q  <= rply_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    pkt_d       = pkt_q;
    cnt_d       = cnt_q;
    rply_d      = rply_q;
    rd_d        = rd_q;
    err_d       = err_q;
    done0       = 1'b0;
    done1       = 1'b0;
    rd_data     = '0;
    err         = 1'b0;
    tx_data     = '0;
    ld_tx_data  = 1'b0;
    uld_rx_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale reply is flushed before any new command is granted
        if (!rx_empty) begin
          uld_rx_data = !reset;
        end else if (req0 || req1) begin
          gnt_d   = sel;
          pkt_d   = sel ? mk_pkt(wrb1, addr1, data1)
                        : mk_pkt(wrb0, addr0, data0);
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data    = pkt_q;
        ld_tx_data = 1'b1;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (pkt_q[0]) begin
            cnt_d   = '0;
            state_d = WAIT_RX;
          end else begin
            rd_d    = '0;
            err_d   = 1'b0;
            state_d = FINISH;
          end
        end
      end
      WAIT_RX: begin
        if (!rx_empty) begin
          state_d = UNLOAD;
        end else if (cnt_q == TmoLast) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      UNLOAD: begin
        uld_rx_data = 1'b1;
        rply_d      = rx_data;
        state_d     = CHECK;
      end
      CHECK: begin
        err_d   = bad;
        rd_d    = bad ? 8'h00 : rply_q[8:1];
        state_d = FINISH;
      end
      FINISH: begin
        done0   = !gnt_q;
        done1   = gnt_q;
        rd_data = rd_q;
        err     = err_q;
        ptr_d   = !gnt_q;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// tb_uart_cmd_scheduler: scoreboard bench for uart_cmd_scheduler.
// A UART model replies to reads; a monitor checks every done pulse against a queue.
module tb_uart_cmd_scheduler;

  localparam int T = 40;
  localparam int M_WR = 0, M_GOOD = 1, M_BADADDR = 2, M_BADWRB = 3;
  localparam int M_BADPAR = 4, M_TMO = 5, M_RST = 6;
`ifdef PARITY_CHECK_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  typedef struct {
    int          id;
    int          mode;
    logic [7:0]  addr;
    logic [7:0]  dat;
    logic [17:0] pkt;
    logic [17:0] rpl;
    logic        err;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, wrb0, wrb1;
  logic [7:0]  addr0, addr1, data0, data1;
  logic        done0, done1, err;
  logic [7:0]  rd_data;
  logic [17:0] tx_data, rx_data;
  logic        ld_tx_data, tx_busy, rx_empty, uld_rx_data;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_srv = 1;
  int   busy_len = 1;
  bit   inj_req = 1'b0;
  logic [17:0] inj_word = '0;
  txn_t ld_q[$];
  txn_t done_q[$];
  int   tmo_q[$];
  int   mtab[8] = '{M_GOOD, M_GOOD, M_BADADDR, M_BADWRB,
                    M_BADPAR, M_TMO, M_GOOD, M_GOOD};

  uart_cmd_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wrb0(wrb0), .wrb1(wrb1),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .done0(done0), .done1(done1), .rd_data(rd_data), .err(err),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_empty(rx_empty), .uld_rx_data(uld_rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  function automatic txn_t mk(input int id, input int mode,
                              input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    logic [16:0] b;
    logic [7:0] x;
    t.id = id; t.mode = mode; t.addr = a; t.dat = d;
    b = {a, (mode == M_WR) ? d : 8'h00, mode != M_WR};
    t.pkt = {^b, b};
    x = 8'($urandom_range(1, 255));
    t.rpl = '0;
    t.err = 1'b0;
    case (mode)
      M_GOOD:    begin b = {a, d, 1'b1};     t.rpl = {^b, b}; end
      M_BADADDR: begin b = {a ^ x, d, 1'b1}; t.rpl = {^b, b}; t.err = 1'b1; end
      M_BADWRB:  begin b = {a, d, 1'b0};     t.rpl = {^b, b}; t.err = 1'b1; end
      M_BADPAR:  begin b = {a, d, 1'b1};     t.rpl = {~^b, b}; t.err = ParEn; end
      M_TMO:     t.err = 1'b1;
      default:   ;
    endcase
    return t;
  endfunction

  function automatic txn_t rand_txn(input int id);
    int m;
    m = ($urandom_range(0, 1) == 0) ? M_WR : mtab[$urandom_range(0, 7)];
    return mk(id, m, 8'($urandom), 8'($urandom));
  endfunction

  task automatic set_req(input int id, input logic v);
    if (id == 0) req0 = v; else req1 = v;
  endtask

  task automatic issue(input int id, input txn_t t, input bit early,
                       output int rcyc, output int dcyc);
    logic dn;
    @(negedge clk);
    rcyc = cyc;
    if (id == 0) begin
      wrb0 = (t.mode != M_WR); addr0 = t.addr; data0 = t.dat;
    end else begin
      wrb1 = (t.mode != M_WR); addr1 = t.addr; data1 = t.dat;
    end
    set_req(id, 1'b1);
    dcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      dn = (id == 0) ? done0 : done1;
      if (dn) begin
        dcyc = cyc;
        break;
      end
      if (early && ld_tx_data) set_req(id, 1'b0);
    end
    set_req(id, 1'b0);
    if (dcyc < 0) fail("req_timeout");
  endtask

  // UART transmitter/receiver model
  initial begin : uart_model
    txn_t t;
    int n, d, l, k;
    tx_busy = 1'b0; rx_empty = 1'b1; rx_data = '0;
    forever begin
      @(negedge clk);
      if (inj_req) begin
        inj_req = 1'b0;
        rx_data = inj_word; rx_empty = 1'b0;
        @(posedge clk); #1 rx_empty = 1'b1;
      end else if (ld_tx_data === 1'b1) begin
        if (ld_q.size() == 0) begin
          fail("ld_unexpected");
        end else begin
          t = ld_q.pop_front();
          check("tx_pkt", 32'(tx_data), 32'(t.pkt));
          n = (busy_len > 0) ? busy_len : $urandom_range(1, 3);
          l = cyc;
          @(posedge clk); #1 tx_busy = 1'b1;
          repeat (n) @(posedge clk);
          #1 tx_busy = 1'b0;
          if (t.mode == M_TMO) tmo_q.push_back(l + n + 2 + T);
          if (t.mode inside {M_GOOD, M_BADADDR, M_BADWRB, M_BADPAR}) begin
            d = $urandom_range(0, 6);
            repeat (d) @(posedge clk);
            if (d > 0) #1;
            rx_data = t.rpl; rx_empty = 1'b0;
            for (k = 0; k < 100; k++) begin
              @(negedge clk);
              if (uld_rx_data) break;
            end
            if (k == 100) fail("uld_missing");
            @(posedge clk); #1 rx_empty = 1'b1;
          end
        end
      end
    end
  end

  // Done monitor / scoreboard
  initial begin : monitor
    txn_t e;
    int x;
    forever begin
      @(negedge clk);
      if (done0 || done1) begin
        check("done_onehot", 32'(done0 & done1), 32'd0);
        if (done_q.size() == 0) begin
          fail("done_unexpected");
        end else begin
          e = done_q.pop_front();
          check("done_id", done1 ? 32'd1 : 32'd0, 32'(e.id));
          check("err", 32'(err), 32'(e.err));
          if (e.mode == M_GOOD || (e.mode == M_BADPAR && !e.err))
            check("rd_data", 32'(rd_data), 32'(e.dat));
          if (e.mode == M_TMO) begin
            check("tmo_rd", 32'(rd_data), 32'd0);
            x = (tmo_q.size() > 0) ? tmo_q.pop_front() : -1;
            check("tmo_cycle", 32'(cyc), 32'(x));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  task automatic push(input txn_t t);
    ld_q.push_back(t);
    done_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_srv = 1;
  endtask

  initial begin : main
    txn_t a, b;
    logic [16:0] w;
    int r0, d0, r1, d1, sc, id;
    reset = 1'b1;
    req0 = 0; req1 = 0; wrb0 = 0; wrb1 = 0;
    addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_ld", 32'(ld_tx_data), 32'd0);
    check("rst_uld", 32'(uld_rx_data), 32'd0);
    check("rst_done", 32'({done0, done1}), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    last_srv = 1;

    // single write, minimum latency
    busy_len = 1;
    a = mk(0, M_WR, 8'h01, 8'hab);
    a.pkt = 18'h00356;
    push(a); last_srv = 0;
    issue(0, a, 1'b0, r0, d0);
    check("wr_latency", 32'(d0 - r0), 32'd4);

    // read
    a = mk(1, M_GOOD, 8'h01, 8'hab);
    push(a); last_srv = 1;
    issue(1, a, 1'b0, r0, d0);

    // contention after reset, twice
    do_reset();
    repeat (2) begin
      a = mk(0, M_WR, 8'h10, 8'h11);
      b = mk(1, M_GOOD, 8'h20, 8'h22);
      if (last_srv == 0) begin push(b); push(a); last_srv = 0; end
      else begin push(a); push(b); last_srv = 1; end
      fork
        issue(0, a, 1'b0, r0, d0);
        issue(1, b, 1'b0, r1, d1);
      join
    end

    // timeout, bad address, bad parity, bad wrb
    a = mk(0, M_TMO, 8'h33, 8'h00);
    push(a); last_srv = 0;
    issue(0, a, 1'b0, r0, d0);
    a = mk(0, M_BADADDR, 8'h01, 8'h55);
    w = {8'h02, 8'h55, 1'b1};
    a.rpl = {^w, w};
    push(a);
    issue(0, a, 1'b0, r0, d0);
    a = mk(1, M_BADPAR, 8'h44, 8'h5a);
    push(a); last_srv = 1;
    issue(1, a, 1'b0, r0, d0);
    a = mk(1, M_BADWRB, 8'h45, 8'h5b);
    push(a);
    issue(1, a, 1'b0, r0, d0);

    // reset during WAIT_RX, then late reply drained in IDLE
    a = mk(1, M_RST, 8'h05, 8'h77);
    ld_q.push_back(a);
    @(negedge clk);
    wrb1 = 1'b1; addr1 = 8'h05; data1 = 8'h77; req1 = 1'b1;
    for (int k = 0; k < 50 && !ld_tx_data; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    reset = 1'b1; req1 = 1'b0;
    #1 check("rst_mid_done", 32'({done0, done1}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; last_srv = 1;
    @(posedge clk); #1;
    w = {8'h05, 8'h99, 1'b1};
    inj_word = {^w, w}; inj_req = 1'b1;
    @(negedge clk); #1;
    check("drain_uld", 32'(uld_rx_data), 32'd1);
    repeat (4) @(negedge clk);

    // stale reply with a pending write costs one extra cycle
    @(posedge clk); #1;
    inj_word = {^w, w}; inj_req = 1'b1;
    a = mk(0, M_WR, 8'h66, 8'h67);
    push(a); last_srv = 0;
    fork
      issue(0, a, 1'b0, r0, d0);
      begin
        @(negedge clk); #1;
        check("stale_uld", 32'(uld_rx_data), 32'd1);
      end
    join
    check("stale_latency", 32'(d0 - r0), 32'd5);

    // randomized traffic
    busy_len = 0;
    for (int i = 0; i < 60; i++) begin
      sc = $urandom_range(0, 2);
      if (sc < 2) begin
        id = $urandom_range(0, 1);
        a = rand_txn(id);
        push(a); last_srv = id;
        issue(id, a, ($urandom_range(0, 3) == 0), r0, d0);
      end else begin
        a = rand_txn(0);
        b = rand_txn(1);
        if (last_srv == 0) begin push(b); push(a); last_srv = 0; end
        else begin push(a); push(b); last_srv = 1; end
        fork
          issue(0, a, 1'b0, r0, d0);
          issue(1, b, 1'b0, r1, d1);
        join
      end
    end

    repeat (10) @(negedge clk);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    check("ld_q_empty", 32'(ld_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
